// File: rtl/regfile_pkg.sv
// Register-file writeback package.
// Shared constants and types for the writeback arbiter and its arbitration core.
//   NUM_REGS  : number of architectural registers
//   REG_AW    : register index width
//   REG_ZERO  : index of the hard-wired zero register (writes are dropped)
//   XLEN_DEF  : default architectural data width
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned XLEN_DEF = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        logic                valid;
        reg_idx_t            rd;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Scans req starting at ptr and wrapping modulo NREQ; the first set bit wins.
// The pointer register lives in the parent.
//   req_i  : request vector
//   ptr_i  : index with highest priority this cycle (must be < NREQ)
//   en_i   : when low no grant is produced
//   gnt_o  : one-hot grant (or zero)
//   idx_o  : encoded index of the granted requester (0 when no grant)
//   any_o  : a grant exists this cycle
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    int unsigned k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // Explicit wrap so non-power-of-two NREQ never selects a missing slot.
            k = int'(ptr_i) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (en_i && !any_o && req_i[k]) begin
                gnt_o[k] = 1'b1;
                idx_o    = PW'(k);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port among NREQ
// writeback requesters using round-robin arbitration and valid/ready handshakes.
// The winning write is registered and presented on rf_* one cycle after accept.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset
//   req_valid_i  : per-requester write request
//   req_rd_i     : packed destination indices, requester k at [k*REG_AW +: REG_AW]
//   req_data_i   : packed write data, requester k at [k*XLEN +: XLEN]
//   req_ready_o  : one-hot combinational grant
//   hold_i       : blocks new grants; the registered write still drains
//   rf_we_o      : register-file write enable (never set for x0)
//   rf_rd_o      : register-file write index
//   rf_data_o    : register-file write data
//   busy_o       : a write is on the port or a request is pending
// Optional (macro REGFILE_WB_BYPASS_EN): read-during-write forwarding mux
//   byp_rs1_i/byp_rs2_i, rf_op1_i/rf_op2_i in; byp_op1_o/byp_op2_o out.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREQ   = 3,
    parameter int unsigned REG_AW = regfile_pkg::REG_AW
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*REG_AW-1:0] req_rd_i,
    input  logic [NREQ*XLEN-1:0]   req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic                   hold_i,
    output logic                   rf_we_o,
    output logic [REG_AW-1:0]      rf_rd_o,
    output logic [XLEN-1:0]        rf_data_o,
    output logic                   busy_o
`ifdef REGFILE_WB_BYPASS_EN
   ,input  logic [REG_AW-1:0]      byp_rs1_i,
    input  logic [REG_AW-1:0]      byp_rs2_i,
    input  logic [XLEN-1:0]        rf_op1_i,
    input  logic [XLEN-1:0]        rf_op2_i,
    output logic [XLEN-1:0]        byp_op1_o,
    output logic [XLEN-1:0]        byp_op2_o
`endif
);

    import regfile_pkg::*;

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_q;
    logic [NREQ-1:0]   gnt;
    logic [PW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic              rf_we_q;
    logic [REG_AW-1:0] rf_rd_q;
    logic [XLEN-1:0]   rf_data_q;

    // Gating with rst_ni keeps ready low for the whole reset window.
    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .en_i  (~hold_i & rst_ni),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // One-hot grant mux with constant slice bases.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_rd   = req_rd_i[k*REG_AW +: REG_AW];
                sel_data = req_data_i[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else if (gnt_any) begin
            rf_rd_q   <= sel_rd;
            rf_data_q <= sel_data;
            // x0 writes complete the handshake but never reach the register file.
            rf_we_q   <= (sel_rd != REG_AW'(REG_ZERO));
            ptr_q     <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
            rf_we_q   <= 1'b0;
        end
    end

    assign req_ready_o = gnt;
    assign rf_we_o     = rf_we_q;
    assign rf_rd_o     = rf_rd_q;
    assign rf_data_o   = rf_data_q;
    assign busy_o      = rf_we_q | (|req_valid_i);

`ifdef REGFILE_WB_BYPASS_EN
    // The register file still returns the old value in the cycle it commits,
    // so forward the pending write. x0 is never forwarded.
    always_comb begin
        byp_op1_o = rf_op1_i;
        byp_op2_o = rf_op2_i;
        if (rf_we_q && (rf_rd_q == byp_rs1_i) && (byp_rs1_i != REG_AW'(REG_ZERO))) begin
            byp_op1_o = rf_data_q;
        end
        if (rf_we_q && (rf_rd_q == byp_rs2_i) && (byp_rs2_i != REG_AW'(REG_ZERO))) begin
            byp_op2_o = rf_data_q;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with NREQ=3, XLEN=32, REG_AW=5.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREQ   = 3;
    localparam int unsigned REG_AW = 5;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        valid;
    logic [NREQ*REG_AW-1:0] rd_in;
    logic [NREQ*XLEN-1:0]   data_in;
    logic [NREQ-1:0]        ready;
    logic                   hold;
    logic                   we;
    logic [REG_AW-1:0]      rd_out;
    logic [XLEN-1:0]        data_out;
    logic                   busy;
`ifdef REGFILE_WB_BYPASS_EN
    logic [REG_AW-1:0]      rs1;
    logic [REG_AW-1:0]      rs2;
    logic [XLEN-1:0]        op1;
    logic [XLEN-1:0]        op2;
    logic [XLEN-1:0]        byp1;
    logic [XLEN-1:0]        byp2;
`endif

    int n_vec;
    int n_err;

    regfile_wb_arbiter #(
        .XLEN   (XLEN),
        .NREQ   (NREQ),
        .REG_AW (REG_AW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (valid),
        .req_rd_i    (rd_in),
        .req_data_i  (data_in),
        .req_ready_o (ready),
        .hold_i      (hold),
        .rf_we_o     (we),
        .rf_rd_o     (rd_out),
        .rf_data_o   (data_out),
        .busy_o      (busy)
`ifdef REGFILE_WB_BYPASS_EN
       ,.byp_rs1_i   (rs1),
        .byp_rs2_i   (rs2),
        .rf_op1_i    (op1),
        .rf_op2_i    (op2),
        .byp_op1_o   (byp1),
        .byp_op2_o   (byp2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [REG_AW-1:0] r, input logic [XLEN-1:0] d);
        rd_in[k*REG_AW +: REG_AW] = r;
        data_in[k*XLEN +: XLEN]   = d;
    endtask

    // Registered outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        hold    = 1'b0;
        valid   = '0;
        rd_in   = '0;
        data_in = '0;
`ifdef REGFILE_WB_BYPASS_EN
        rs1 = '0;
        rs2 = '0;
        op1 = '0;
        op2 = '0;
`endif
        set_req(0, 5'd1, 32'h0000_0100);
        set_req(1, 5'd2, 32'h0000_0101);
        set_req(2, 5'd3, 32'h0000_0102);
        valid = 3'b111;

        // Reset state, with all requesters valid.
        #12;
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_rd", 32'(rd_out), 32'd0);
        chk("reset_data", data_out, 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        rst_n = 1'b1;
        #1;

        // All valid: round robin 0,1,2,0,1,2.
        for (int c = 0; c < 6; c++) begin
            logic [NREQ-1:0] one;
            one = 3'b001;
            chk("rr_ready", 32'(ready), 32'(one << (c % 3)));
            tick();
            chk("rr_we", 32'(we), 32'd1);
            chk("rr_rd", 32'(rd_out), 32'((c % 3) + 1));
            chk("rr_data", data_out, 32'h100 + 32'(c % 3));
        end

        // Single requester 1, rd=5.
        valid = 3'b010;
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("single_ready", 32'(ready), 32'b010);
        tick();
        valid = 3'b000;
        chk("single_we", 32'(we), 32'd1);
        chk("single_rd", 32'(rd_out), 32'd5);
        chk("single_data", data_out, 32'hDEAD_BEEF);
        chk("single_busy", 32'(busy), 32'd1);
        tick();
        chk("single_we_off", 32'(we), 32'd0);
        chk("single_rd_hold", 32'(rd_out), 32'd5);
        chk("single_data_hold", data_out, 32'hDEAD_BEEF);
        chk("idle_busy", 32'(busy), 32'd0);

        // Write to x0 from requester 0 is consumed without a write enable.
        valid = 3'b001;
        set_req(0, 5'd0, 32'h0000_1234);
        #1;
        chk("x0_ready", 32'(ready), 32'b001);
        tick();
        chk("x0_we", 32'(we), 32'd0);
        chk("x0_busy", 32'(busy), 32'd1);

        // Pointer now 1: all valid grants requester 1.
        set_req(0, 5'd1, 32'h0000_0100);
        set_req(1, 5'd2, 32'h0000_0101);
        valid = 3'b111;
        #1;
        chk("ptr1_ready", 32'(ready), 32'b010);
        tick();
        chk("ptr1_rd", 32'(rd_out), 32'd2);

        // Requester 2 granted, then hold for 3 cycles.
        chk("t_ready", 32'(ready), 32'b100);
        tick();
        hold = 1'b1;
        #1;
        chk("hold_drain_we", 32'(we), 32'd1);
        chk("hold_drain_rd", 32'(rd_out), 32'd3);
        chk("hold_ready0", 32'(ready), 32'd0);
        tick();
        chk("hold_we_off", 32'(we), 32'd0);
        chk("hold_ready1", 32'(ready), 32'd0);
        tick();
        chk("hold_ready2", 32'(ready), 32'd0);
        tick();
        hold = 1'b0;
        #1;
        chk("release_ready", 32'(ready), 32'b001);
        tick();
        chk("release_we", 32'(we), 32'd1);
        chk("release_rd", 32'(rd_out), 32'd1);

        // Asynchronous reset mid-cycle while a write is pending.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_rd", 32'(rd_out), 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        tick();
        chk("arst_ready_edge", 32'(ready), 32'd0);
        chk("arst_we_edge", 32'(we), 32'd0);
        #3;
        rst_n = 1'b1;
        #1;
        chk("arst_ptr0_ready", 32'(ready), 32'b001);

`ifdef REGFILE_WB_BYPASS_EN
        // Forwarding during the commit cycle.
        valid = 3'b001;
        set_req(0, 5'd7, 32'hA5A5_A5A5);
        tick();
        valid = 3'b000;
        rs1   = 5'd7;
        rs2   = 5'd0;
        op1   = 32'h0000_0002;
        op2   = 32'h0000_0001;
        #1;
        chk("byp_we", 32'(we), 32'd1);
        chk("byp_op1", byp1, 32'hA5A5_A5A5);
        chk("byp_op2", byp2, 32'h0000_0001);
        tick();
        chk("byp_op1_nowe", byp1, 32'h0000_0002);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/rd/data) among NREQ writeback requesters, e.g. ALU, load unit and CSR/mul-div.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write and drives it to the register file's write port one cycle after acceptance.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of one architectural register.
- NREQ, 3, number of writeback requesters (2..8).
- REG_AW, 5, register index width (32 registers).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  NREQ  per-requester write request.
- req_rd_i  input  NREQ*REG_AW  destination index; requester k uses bits [k*REG_AW +: REG_AW].
- req_data_i  input  NREQ*XLEN  write data; requester k uses bits [k*XLEN +: XLEN].
- req_ready_o  output  NREQ  one-hot grant; handshake completes when valid and ready are both high.
- hold_i  input  1  when high, no new grants are issued; the output stage still drains.
- rf_we_o  output  1  register-file write enable.
- rf_rd_o  output  REG_AW  register-file write index.
- rf_data_o  output  XLEN  register-file write data.
- busy_o  output  1  high while rf_we_o is high or any req_valid_i bit is high.

Behaviour:
- Reset (async assert, sync deassert expected from the reset tree):
  - rf_we_o=0, rf_rd_o=0, rf_data_o=0.
  - Round-robin pointer ptr=0.
  - req_ready_o is combinational and therefore 0 while rst_ni=0.
- Grant (combinational, same cycle):
  - When hold_i=0 and at least one valid is high, grant the first valid requester scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready_o is one-hot or zero.
  - It never depends on a requester's own ready; no combinational valid-to-valid loops.
- Accept: on the rising edge where a grant exists:
  - rf_rd_o <= granted rd and rf_data_o <= granted data.
  - rf_we_o <= 1 only if the granted rd != 0.
  - A write to x0 is consumed (handshake completes) but produces rf_we_o=0.
- No grant in a cycle: rf_we_o <= 0; rf_rd_o and rf_data_o hold their previous values.
- Latency: exactly 1 cycle from accept to rf_we_o. The register file commits on the following edge.
- Throughput: one write per cycle. The output stage never stalls because the register file always accepts.
- Pointer update: on accept, ptr <= (granted index + 1) mod NREQ; otherwise ptr holds. The wrap for non-power-of-two NREQ is explicit.
- Fairness: with all requesters continuously valid, each is granted once every NREQ cycles.
- Requester contract: valid must stay high with stable rd/data until ready. The arbiter does not check this.
- hold_i asserted mid-stream: the write already registered still appears on rf_we_o the next cycle. No further grants occur and ptr is frozen.
- Reset asserted mid-operation: any in-flight registered write is dropped (rf_we_o=0 immediately, asynchronously). Requesters must re-issue.
- busy_o is combinational from rf_we_o and req_valid_i.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: adds the following ports.
  - byp_rs1_i, byp_rs2_i: input, REG_AW each.
  - rf_op1_i, rf_op2_i: input, XLEN each; these are the register-file read data.
  - byp_op1_o, byp_op2_o: output, XLEN each.
- Forwarding rule:
  - byp_opN_o = rf_data_o when rf_we_o=1 and rf_rd_o==byp_rsN_i and byp_rsN_i!=0.
  - Otherwise byp_opN_o = rf_opN_i.
  - Purely combinational.
  - Covers the read-during-write cycle in which the register file still returns the old value.
- Undefined: these ports and the mux logic are absent; there is no other behavioural change.

Decomposition:
- Package regfile_pkg:
  - constants NUM_REGS=32, REG_AW=5, REG_ZERO=0.
  - typedef reg_idx_t, plus a wb_req_t struct {valid, rd, data}.
- Sub-module rr_arbiter: parameterised NREQ round-robin picker.
  - Inputs: req vector, ptr, enable.
  - Output: one-hot grant plus encoded index.
  - Purely combinational; ptr state stays in the parent.

Test Plan:
- After reset, req_valid_i=3'b111, hold_i=0 for 6 cycles, rd=1/2/3 for req0/1/2 → ready order 0,1,2,0,1,2; rf_we_o=1 from cycle 2 with rf_rd_o sequence 1,2,3,1,2,3.
- Only req1 valid, rd=5, data=32'hDEADBEEF → ready[1]=1 same cycle; next cycle rf_we_o=1, rf_rd_o=5, rf_data_o=32'hDEADBEEF; following cycle rf_we_o=0.
- req0 valid, rd=0, data=32'h1234 → ready[0]=1 and handshake completes; next cycle rf_we_o=0; ptr advances to 1.
- req2 granted at cycle t, hold_i=1 from t+1 for 3 cycles with all valid → rf_we_o=1 at t+1 only; ready=0 during hold; after release, grant goes to req0 (ptr=0).
- rst_ni pulsed low asynchronously mid-cycle while rf_we_o=1 → rf_we_o=0 immediately; ptr=0; req_ready_o=0 until release.
- With REGFILE_WB_BYPASS_EN defined: rf_we_o=1, rf_rd_o=7, rf_data_o=32'hA5A5A5A5, byp_rs1_i=7, byp_rs2_i=0, rf_op2_i=32'h1 → byp_op1_o=32'hA5A5A5A5, byp_op2_o=32'h1.
